// File: rtl/mpu_dispatch_sequencer.sv
// Dispatch read sequencer for the MPU matrix multiply: walks (i, j, k), reads A[i][k]/B[k][j]
// from the register file and forwards tagged operand pairs to the execution unit through a 2-entry FIFO.
module mpu_dispatch_sequencer #(
    parameter int MATRIX_REGISTERS = 8,
    parameter int M = 4,
    parameter int N = 4,
    parameter int RAW = $clog2(MATRIX_REGISTERS),
    parameter int IW = $clog2((M > N) ? M : N),
    parameter int SW = $clog2(((M > N) ? M : N) + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_in,
    input  logic           abort_in,
    input  logic [RAW-1:0] a_addr_in,
    input  logic [RAW-1:0] b_addr_in,
    input  logic [SW-1:0]  m_size_in,
    input  logic [SW-1:0]  k_size_in,
    input  logic [SW-1:0]  n_size_in,
    output logic           busy_out,
    output logic           done_out,
    output logic           err_out,
    output logic           reg_disp_req_out,
    input  logic           reg_disp_ready_in,
    output logic [RAW-1:0] reg_disp_addr_0_out,
    output logic [RAW-1:0] reg_disp_addr_1_out,
    output logic [IW-1:0]  reg_disp_0_i_out,
    output logic [IW-1:0]  reg_disp_0_j_out,
    output logic [IW-1:0]  reg_disp_1_i_out,
    output logic [IW-1:0]  reg_disp_1_j_out,
    input  logic [31:0]    reg_disp_element_0_in,
    input  logic [31:0]    reg_disp_element_1_in,
    output logic           exec_valid_out,
    input  logic           exec_ready_in,
    output logic [31:0]    exec_a_out,
    output logic [31:0]    exec_b_out,
    output logic [IW-1:0]  exec_i_out,
    output logic [IW-1:0]  exec_j_out,
    output logic           exec_last_out
);

    localparam int KMAX = (M < N) ? M : N;
    localparam logic [SW-1:0] ONE_SW = SW'(1);
    localparam logic [IW-1:0] ONE_IW = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [RAW-1:0] a_addr_r, b_addr_r;
    logic [SW-1:0]  m_r, k_r, n_r;
    logic [IW-1:0]  i_r, j_r, k_cnt_r;
    logic           err_r, err_s;
    logic           busy_r, done_r, err_out_r;
    logic           pending_r;
    logic [IW-1:0]  tag_i_r, tag_j_r;
    logic           tag_last_r;
    logic [31:0]    a_mem_r [2];
    logic [31:0]    b_mem_r [2];
    logic [IW-1:0]  i_mem_r [2];
    logic [IW-1:0]  j_mem_r [2];
    logic           last_mem_r [2];
    logic           wr_ptr_r, rd_ptr_r;
    logic [1:0]     count_r;

    logic           pop_s, push_s, credit_ok_s, req_s, issue_s;
    logic           k_last_s, j_last_s, i_last_s, last_issue_s, sizes_ok_s;

    // Handshake, credit and index-wrap decode
    always_comb begin
        pop_s        = (count_r != 2'd0) & exec_ready_in;
        push_s       = pending_r;
        // Requests in flight plus buffered entries never exceed the FIFO depth.
        credit_ok_s  = (({1'b0, count_r} + {2'b00, pending_r}) - {2'b00, pop_s}) < 3'd2;
        req_s        = (state_r == S_RUN) & credit_ok_s;
        issue_s      = req_s & reg_disp_ready_in;
        k_last_s     = (SW'(k_cnt_r) == (k_r - ONE_SW));
        j_last_s     = (SW'(j_r) == (n_r - ONE_SW));
        i_last_s     = (SW'(i_r) == (m_r - ONE_SW));
        last_issue_s = issue_s & k_last_s & j_last_s & i_last_s;
        sizes_ok_s   = (m_r != {SW{1'b0}}) && (k_r != {SW{1'b0}}) && (n_r != {SW{1'b0}}) &&
                       (m_r <= SW'(M)) && (n_r <= SW'(N)) && (k_r <= SW'(KMAX));
    end

    // Next-state and error-flag logic
    always_comb begin
        state_s = state_r;
        err_s   = (state_r == S_CHECK) ? ~sizes_ok_s : err_r;
        if (abort_in) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_in) state_s = S_CHECK;
                    else          state_s = S_IDLE;
                end
                S_CHECK: begin
                    if (sizes_ok_s) state_s = S_RUN;
                    else            state_s = S_DONE;
                end
                S_RUN: begin
                    if (last_issue_s) state_s = S_DRAIN;
                    else              state_s = S_RUN;
                end
                S_DRAIN: begin
                    if (!pending_r && ((count_r - {1'b0, pop_s}) == 2'd0)) state_s = S_DONE;
                    else                                                   state_s = S_DRAIN;
                end
                S_DONE:  state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_out_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            err_r     <= err_s;
            busy_r    <= (state_s != S_IDLE);
            done_r    <= (state_s == S_DONE);
            err_out_r <= (state_s == S_DONE) & err_s;
        end
    end

    // Command latch: operands are frozen for the whole command
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr_r <= {RAW{1'b0}};
            b_addr_r <= {RAW{1'b0}};
            m_r      <= {SW{1'b0}};
            k_r      <= {SW{1'b0}};
            n_r      <= {SW{1'b0}};
        end else if ((state_r == S_IDLE) && start_in && !abort_in) begin
            a_addr_r <= a_addr_in;
            b_addr_r <= b_addr_in;
            m_r      <= m_size_in;
            k_r      <= k_size_in;
            n_r      <= n_size_in;
        end else begin
            a_addr_r <= a_addr_r;
            b_addr_r <= b_addr_r;
            m_r      <= m_r;
            k_r      <= k_r;
            n_r      <= n_r;
        end
    end

    // Index counters (k innermost) and the in-flight tag side register
    always_ff @(posedge clk) begin
        if (rst || abort_in) begin
            i_r        <= {IW{1'b0}};
            j_r        <= {IW{1'b0}};
            k_cnt_r    <= {IW{1'b0}};
            pending_r  <= 1'b0;
            tag_i_r    <= {IW{1'b0}};
            tag_j_r    <= {IW{1'b0}};
            tag_last_r <= 1'b0;
        end else begin
            pending_r <= issue_s;
            if (issue_s) begin
                tag_i_r    <= i_r;
                tag_j_r    <= j_r;
                tag_last_r <= k_last_s;
                if (last_issue_s) begin
                    i_r     <= {IW{1'b0}};
                    j_r     <= {IW{1'b0}};
                    k_cnt_r <= {IW{1'b0}};
                end else if (k_last_s) begin
                    k_cnt_r <= {IW{1'b0}};
                    if (j_last_s) begin
                        j_r <= {IW{1'b0}};
                        i_r <= i_r + ONE_IW;
                    end else begin
                        j_r <= j_r + ONE_IW;
                    end
                end else begin
                    k_cnt_r <= k_cnt_r + ONE_IW;
                end
            end else begin
                tag_i_r    <= tag_i_r;
                tag_j_r    <= tag_j_r;
                tag_last_r <= tag_last_r;
            end
        end
    end

    // Two-entry operand FIFO; data is written the cycle after its request
    always_ff @(posedge clk) begin
        if (rst || abort_in) begin
            for (int e = 0; e < 2; e++) begin
                a_mem_r[e]    <= 32'd0;
                b_mem_r[e]    <= 32'd0;
                i_mem_r[e]    <= {IW{1'b0}};
                j_mem_r[e]    <= {IW{1'b0}};
                last_mem_r[e] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                a_mem_r[wr_ptr_r]    <= reg_disp_element_0_in;
                b_mem_r[wr_ptr_r]    <= reg_disp_element_1_in;
                i_mem_r[wr_ptr_r]    <= tag_i_r;
                j_mem_r[wr_ptr_r]    <= tag_j_r;
                last_mem_r[wr_ptr_r] <= tag_last_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            else       rd_ptr_r <= rd_ptr_r;
            count_r <= (count_r + {1'b0, push_s}) - {1'b0, pop_s};
        end
    end

    assign busy_out            = busy_r;
    assign done_out            = done_r;
    assign err_out             = err_out_r;
    assign reg_disp_req_out    = req_s;
    assign reg_disp_addr_0_out = a_addr_r;
    assign reg_disp_addr_1_out = b_addr_r;
    assign reg_disp_0_i_out    = i_r;
    assign reg_disp_0_j_out    = k_cnt_r;
    assign reg_disp_1_i_out    = k_cnt_r;
    assign reg_disp_1_j_out    = j_r;
    assign exec_valid_out      = (count_r != 2'd0);
    assign exec_a_out          = a_mem_r[rd_ptr_r];
    assign exec_b_out          = b_mem_r[rd_ptr_r];
    assign exec_i_out          = i_mem_r[rd_ptr_r];
    assign exec_j_out          = j_mem_r[rd_ptr_r];
    assign exec_last_out       = last_mem_r[rd_ptr_r];

endmodule

// File: doc/mpu_dispatch_sequencer.md
# mpu_dispatch_sequencer

Sequences the dispatch read port of the MPU matrix register file for a matrix multiply C = A×B. On a start command it walks the (i, j, k) index space and issues one element-pair read per cycle: A[i][k] and B[k][j]. It buffers the returned pairs and hands them to the execution unit over a valid/ready handshake, tagged with the output location and a last-of-dot-product flag. It sits between the MPU controller (command side), the register file dispatch port, and the execution unit.

## Interface
- MATRIX_REGISTERS, 8, number of matrix registers; RAW = $clog2(MATRIX_REGISTERS)
- M, 4, max rows per register; N, 4, max columns per register
- Derived widths: IW = $clog2(max(M,N)); SW = $clog2(max(M,N)+1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_in  in  1  command pulse; sampled only in IDLE
- abort_in  in  1  flush and return to IDLE
- a_addr_in, b_addr_in  in  RAW  operand register addresses
- m_size_in, k_size_in, n_size_in  in  SW  A is m×k, B is k×n
- busy_out  out  1  high in any state other than IDLE
- done_out  out  1  one-cycle completion pulse
- err_out  out  1  qualifies done_out: the command had illegal sizes
- reg_disp_req_out  out  1  dispatch read request
- reg_disp_ready_in  in  1  register file dispatch ready (combinational from addresses)
- reg_disp_addr_0_out, reg_disp_addr_1_out  out  RAW  equal to latched a_addr and b_addr
- reg_disp_0_i_out, reg_disp_0_j_out  out  IW  equal to i and k
- reg_disp_1_i_out, reg_disp_1_j_out  out  IW  equal to k and j
- reg_disp_element_0_in, reg_disp_element_1_in  in  32  data, valid the cycle after req&ready
- exec_valid_out  out  1  pair available
- exec_ready_in  in  1  execution unit accepts
- exec_a_out, exec_b_out  out  32  operand pair
- exec_i_out, exec_j_out  out  IW  destination element of C
- exec_last_out  out  1  pair has k == k_size-1

## Operation
- States:
  - IDLE: start_in moves to CHECK.
  - CHECK: sizes are legal if m, k, n ≥ 1, m ≤ M, n ≤ N, and k ≤ min(M,N). Legal goes to RUN; illegal goes to DONE with err set.
  - RUN: issues requests. After the last index is issued, goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and nothing is pending, then goes to DONE.
  - DONE: asserts done_out for one cycle, then returns to IDLE.
- Addresses and sizes are latched on start and held constant until IDLE.
- Index order: k innermost, then j, then i. Counters start at 0.
  - k wraps at k_size-1 and increments j.
  - j wraps at n_size-1 and increments i.
  - The last issue is (m-1, n-1, k-1).
- Issue condition: state RUN, reg_disp_ready_in, and (fifo_count + pending − pop) < 2.
  - pending is a 1-bit flag: an issue happened last cycle.
  - pop = exec_valid_out & exec_ready_in.
- Counters advance only on an issue.
- A 2-entry FIFO holds {a, b, i, j, last}.
  - The i/j/last tags travel in a 1-cycle side register alongside pending.
  - The FIFO write occurs in the cycle pending is high.
- exec_valid_out = FIFO non-empty. Outputs are driven from the FIFO head.
- Simultaneous push and pop when count = 2: not reachable, because the credit rule prevents it.
- abort_in, in any state, on the next edge:
  - state goes to IDLE;
  - FIFO, pending, and counters are cleared;
  - no done_out pulse.
- abort_in has priority over start_in.
- rst mid-operation behaves identically to abort.
- Reset values: busy_out, done_out, err_out, reg_disp_req_out, exec_valid_out = 0. All index, address, and tag outputs = 0.

## Timing
- Start latency:
  - start_in in cycle 0.
  - Cycle 1: CHECK.
  - Cycle 2: first reg_disp_req_out (if ready).
  - Cycle 3: data captured into the FIFO.
  - Cycle 4: exec_valid_out.
- Throughput: one pair per cycle with no stalls. P = m·k·n pairs.
  - Last issue at cycle 1+P.
  - Last valid at cycle 3+P.
- done_out is asserted the cycle after DRAIN sees an empty FIFO following the final pop.
- An illegal command pulses done_out and err_out in cycle 2.
- When reg_disp_ready_in is low, no issue occurs and no data is captured the following cycle.

## Test plan
- 2×2×2 multiply, exec_ready_in held 1:
  - 8 pairs in order (i,j,k) = 000, 001, 010, 011, 100, …;
  - exec_last_out set on odd k;
  - done_out at cycle 12.
- 1×1×1: a single pair with exec_last_out=1; done_out one cycle after its pop.
- Backpressure: 4×4×4 with exec_ready_in low for cycles 5–9.
  - FIFO holds 2 entries; requests stop.
  - No pair is lost or duplicated; all 64 pairs arrive in order.
- reg_disp_ready_in toggling every other cycle: requests are issued only on ready cycles; data order and tags stay correct.
- m_size=0 and, separately, n_size=N+1: no requests; done_out and err_out pulse in cycle 2.
- abort_in in the middle of RUN with 1 FIFO entry and 1 pending:
  - next cycle busy_out=0 and exec_valid_out=0;
  - no done_out;
  - a new start then runs cleanly.
